// File: rtl/pio_in_capture_pkg.sv
// pio_in_capture_pkg: shared constants for the input PIO.
//   - Avalon word addresses of the four slave registers.
//   - EDGE_TYPE encodings and a helper deciding whether a new debounced level counts as an edge.
package pio_in_capture_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int unsigned EDGE_RISING  = 0;
  localparam int unsigned EDGE_FALLING = 1;
  localparam int unsigned EDGE_ANY     = 2;

  // True when a transition to new_val is a capture event for the given edge type.
  function automatic logic edge_match(input int unsigned edge_type, input logic new_val);
    logic m;
    case (edge_type)
      EDGE_RISING:  m = new_val;
      EDGE_FALLING: m = ~new_val;
      default:      m = 1'b1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// pio_debounce_bit: synchronizer plus debounce filter for one asynchronous input bit.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_in           : raw asynchronous input
//   o_level        : debounced level (db_q)
//   o_upd          : high in the cycle whose closing edge changes o_level
//   o_upd_val      : value o_level takes on that edge
module pio_debounce_bit #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_in,
  output logic o_level,
  output logic o_upd,
  output logic o_upd_val
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;
  logic                   r_db;
  logic                   w_upd;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
    // Follow the synchronizer directly.
    assign w_upd = w_sync ^ r_db;
  end else begin : g_debounce
    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_d;
    logic            w_accept;

    // Counter only runs while the input disagrees with db_q and resets on acceptance,
    // so it never exceeds CntMax.
    always_comb begin
      w_cnt_d  = '0;
      w_accept = 1'b0;
      if (w_sync != r_db) begin
        if (r_cnt == CntMax) begin
          w_accept = 1'b1;
        end else begin
          w_cnt_d = r_cnt + CntW'(1);
        end
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= w_cnt_d;
      end
    end

    assign w_upd = w_accept;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_db <= 1'b0;
    end else if (w_upd) begin
      r_db <= w_sync;
    end
  end

  assign o_level   = r_db;
  assign o_upd     = w_upd;
  assign o_upd_val = w_sync;

endmodule

// File: rtl/pio_in_capture.sv
// pio_in_capture: Avalon-MM slave input PIO with debounce, sticky edge capture and interrupt.
// Ports:
//   clk, reset_n         : clock, asynchronous active-low reset
//   address, chipselect,
//   write_n, writedata   : Avalon-MM slave write/select
//   in_port              : asynchronous board inputs
//   readdata             : zero-wait read data (0 data, 1 reserved, 2 irq mask, 3 edge capture W1C)
//   irq                  : |(edge_capture & irq_mask)
module pio_in_capture
  import pio_in_capture_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 0,
  parameter int unsigned EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  // Edges until the first input change can have propagated through sync + debounce.
  localparam int unsigned PrimeCycles =
      SYNC_STAGES + ((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES : 1);
  localparam int unsigned PrimeW = $clog2(PrimeCycles + 1);
  localparam logic [PrimeW-1:0] PrimeMax = PrimeW'(PrimeCycles);

  logic [WIDTH-1:0]  w_level;
  logic [WIDTH-1:0]  w_upd;
  logic [WIDTH-1:0]  w_upd_val;
  logic [WIDTH-1:0]  w_set;
  logic [WIDTH-1:0]  w_clr;
  logic [WIDTH-1:0]  r_mask;
  logic [WIDTH-1:0]  r_edge;
  logic [PrimeW-1:0] r_prime;
  logic              w_primed;
  logic              w_wr;
  logic              w_unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .i_clk    (clk),
      .i_rst_n  (reset_n),
      .i_in     (in_port[i]),
      .o_level  (w_level[i]),
      .o_upd    (w_upd[i]),
      .o_upd_val(w_upd_val[i])
    );
  end

  assign w_wr           = chipselect & ~write_n;
  assign w_primed       = (r_prime == PrimeMax);
  assign w_unused_wdata = ^writedata;

  always_comb begin
    w_set = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (w_upd[i] && w_primed && edge_match(EDGE_TYPE, w_upd_val[i])) begin
        w_set[i] = 1'b1;
      end
    end
  end

  assign w_clr = (w_wr && (address == ADDR_EDGE)) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prime <= '0;
      r_mask  <= '0;
      r_edge  <= '0;
    end else begin
      if (!w_primed) begin
        r_prime <= r_prime + PrimeW'(1);
      end
      if (w_wr && (address == ADDR_MASK)) begin
        r_mask <= writedata[WIDTH-1:0];
      end
      // A new edge in the same cycle as its W1C keeps the bit set.
      r_edge <= (r_edge & ~w_clr) | w_set;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata[WIDTH-1:0] = w_level;
      ADDR_MASK: readdata[WIDTH-1:0] = r_mask;
      ADDR_EDGE: readdata[WIDTH-1:0] = r_edge;
      default:   readdata = '0;
    endcase
  end

  assign irq = |(r_edge & r_mask);

endmodule

// File: tb/tb_pio_in_capture.sv
// tb_pio_in_capture: self-checking bench for pio_in_capture (WIDTH=4, 2 sync stages, debounce 3,
// rising-edge capture). Expected read values are queued when a read is issued and popped when
// readdata is sampled.
module tb_pio_in_capture;
  import pio_in_capture_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  pio_in_capture #(
    .WIDTH          (4),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(3),
    .EDGE_TYPE      (0)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_port),
    .readdata  (readdata),
    .irq       (irq)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, ending 1 time unit after the last one.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic bus_read(input string tag, input logic [1:0] addr, input logic [31:0] exp);
    exp_q.push_back(exp);
    address    = addr;
    chipselect = 1'b1;
    #1;
    check_eq(tag, readdata, exp_q.pop_front());
    chipselect = 1'b0;
  endtask

  task automatic check_irq(input string tag, input logic exp);
    check_eq(tag, {31'b0, irq}, {31'b0, exp});
  endtask

  // Caller is just after a rising edge; the write lands on the next edge.
  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    address    = addr;
    writedata  = data;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = '0;
    in_port    = 4'b0001;

    // 1. Reset state and priming with bit0 high through reset.
    #1;
    bus_read("rst_data", ADDR_DATA, 32'h0);
    bus_read("rst_mask", ADDR_MASK, 32'h0);
    bus_read("rst_edge", ADDR_EDGE, 32'h0);
    check_irq("rst_irq", 1'b0);
    tick(3);
    reset_n = 1'b1;
    tick(4);
    settle();
    bus_read("prime_data_e4", ADDR_DATA, 32'h0);
    tick();
    settle();
    bus_read("prime_data_e5", ADDR_DATA, 32'h1);
    bus_read("prime_edge", ADDR_EDGE, 32'h0);
    check_irq("prime_irq", 1'b0);
    tick(3);
    settle();
    bus_read("prime_edge_late", ADDR_EDGE, 32'h0);
    bus_read("rsvd_read", ADDR_RSVD, 32'h0);

    // 2. Rising capture on bit1 with mask, then W1C.
    tick();
    bus_write(ADDR_MASK, 32'h2);
    in_port[1] = 1'b1;
    tick(4);
    settle();
    bus_read("rise_data_e4", ADDR_DATA, 32'h1);
    bus_read("rise_edge_e4", ADDR_EDGE, 32'h0);
    tick();
    settle();
    bus_read("rise_data_e5", ADDR_DATA, 32'h3);
    bus_read("rise_edge_e5", ADDR_EDGE, 32'h2);
    check_irq("rise_irq", 1'b1);
    tick();
    bus_write(ADDR_EDGE, 32'h2);
    settle();
    bus_read("w1c_edge", ADDR_EDGE, 32'h0);
    bus_read("w1c_mask", ADDR_MASK, 32'h2);
    check_irq("w1c_irq", 1'b0);

    // 3. Two-cycle glitch on bit2 is rejected, a four-cycle pulse is captured.
    tick();
    in_port[2] = 1'b1;
    tick(2);
    in_port[2] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      settle();
      bus_read("glitch_data", ADDR_DATA, 32'h3);
      bus_read("glitch_edge", ADDR_EDGE, 32'h0);
      tick();
    end
    in_port[2] = 1'b1;
    tick(4);
    in_port[2] = 1'b0;
    tick(8);
    settle();
    bus_read("pulse_edge", ADDR_EDGE, 32'h4);
    bus_read("pulse_data", ADDR_DATA, 32'h3);
    check_irq("pulse_irq_masked", 1'b0);
    tick();
    bus_write(ADDR_EDGE, 32'h4);

    // 4. Mask gating on bit0: falling edge is ignored, rising is captured but masked.
    bus_write(ADDR_MASK, 32'h0);
    in_port[0] = 1'b0;
    tick(6);
    settle();
    bus_read("fall_edge", ADDR_EDGE, 32'h0);
    bus_read("fall_data", ADDR_DATA, 32'h2);
    tick();
    in_port[0] = 1'b1;
    tick(6);
    settle();
    bus_read("mask_edge", ADDR_EDGE, 32'h1);
    bus_read("mask_data", ADDR_DATA, 32'h3);
    check_irq("mask_irq_off", 1'b0);
    tick();
    bus_write(ADDR_MASK, 32'h1);
    settle();
    check_irq("mask_irq_on", 1'b1);
    tick();
    bus_write(ADDR_EDGE, 32'h1);
    settle();
    check_irq("mask_irq_clr", 1'b0);

    // 5. W1C of bit3 on the same edge its rising update lands: set wins.
    tick();
    in_port[3] = 1'b1;
    tick(4);
    settle();
    bus_read("simul_pre", ADDR_EDGE, 32'h0);
    address    = ADDR_EDGE;
    writedata  = 32'h8;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    settle();
    bus_read("simul_edge", ADDR_EDGE, 32'h8);
    bus_read("simul_data", ADDR_DATA, 32'hB);

    // 6. Reset while bit0's debounce counter is at 2.
    tick();
    bus_write(ADDR_MASK, 32'hF);
    settle();
    check_irq("pre_rst_irq", 1'b1);
    tick();
    in_port[0] = 1'b0;
    tick(4);
    reset_n = 1'b0;
    bus_read("mid_rst_data", ADDR_DATA, 32'h0);
    bus_read("mid_rst_mask", ADDR_MASK, 32'h0);
    bus_read("mid_rst_edge", ADDR_EDGE, 32'h0);
    check_irq("mid_rst_irq", 1'b0);
    tick(2);
    reset_n = 1'b1;
    tick(4);
    settle();
    bus_read("reprime_data_e4", ADDR_DATA, 32'h0);
    tick();
    settle();
    bus_read("reprime_data_e5", ADDR_DATA, 32'hA);
    bus_read("reprime_edge", ADDR_EDGE, 32'h0);
    tick();
    in_port[0] = 1'b1;
    tick(5);
    settle();
    bus_read("post_prime_edge", ADDR_EDGE, 32'h1);
    bus_read("post_prime_data", ADDR_DATA, 32'hB);
    check_irq("post_prime_irq", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
